// File: rtl/nn_pkg.sv
// Shared definitions for the sequential two-layer perceptron: FSM state
// encoding, configuration address map and the signed clamp used for both
// activation stages.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HID  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Widest accumulator the clamp helper can take without losing bits.
    localparam int CLAMP_W = 32;

    // Base of the output-neuron weights WO[j].
    function automatic int wo_base(input int n_in, input int n_hid);
        return n_in * n_hid;
    endfunction

    // Base of the hidden-neuron biases BH[j].
    function automatic int bh_base(input int n_in, input int n_hid);
        return n_in * n_hid + n_hid;
    endfunction

    // Address of the output bias BO, the last valid entry.
    function automatic int bo_addr(input int n_in, input int n_hid);
        return n_in * n_hid + 2 * n_hid;
    endfunction

    // Address width covering every entry up to and including BO.
    function automatic int cfg_aw(input int n_in, input int n_hid);
        return $clog2(n_in * n_hid + 2 * n_hid + 1);
    endfunction

    // Signed clamp into [lo, hi]; used for ReLU with upper saturation.
    function automatic logic signed [CLAMP_W-1:0] clamp_s(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (v < lo) return lo;
        else if (v > hi) return hi;
        else return v;
    endfunction

endpackage

// File: rtl/nn_mlp_seq_if.sv
// Configuration, start/busy/done handshake and data bus of nn_mlp_seq.
interface nn_mlp_seq_if
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_HID = 3,
    parameter int DW    = 2,
    parameter int BW    = 4,
    parameter int OW    = 2
);
    localparam int AW = cfg_aw(N_IN, N_HID);

    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [BW-1:0]        cfg_data;
    logic                 start;
    logic [N_IN*DW-1:0]   x_in;
    logic                 busy;
    logic                 done;
    logic [OW-1:0]        y;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, x_in,
        input  busy, done, y
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, x_in,
        output busy, done, y
    );

endinterface

// File: rtl/nn_mac.sv
// Shared signed multiply-accumulate: signed coefficient times unsigned data,
// added either to a sign-extended bias (preload) or to the running sum.
module nn_mac
    import nn_pkg::*;
#(
    parameter int DW    = 2,
    parameter int BW    = 4,
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    preload,
    input  logic signed [BW-1:0]    bias,
    input  logic signed [DW-1:0]    coef,
    input  logic [DW-1:0]           data,
    output logic signed [ACC_W-1:0] acc_next
);
    localparam int PW = 2 * DW + 1;

    logic signed [PW-1:0]    coef_x;
    logic signed [PW-1:0]    data_x;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;

    // Data is unsigned, so it is zero-extended before the signed multiply.
    assign coef_x   = PW'(coef);
    assign data_x   = $signed(PW'({1'b0, data}));
    assign prod     = coef_x * data_x;
    assign acc_next = (preload ? ACC_W'(bias) : acc) + ACC_W'(prod);

    // Accumulator register, advanced only while the FSM is evaluating.
    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else if (en) acc <= acc_next;
    end

endmodule

// File: rtl/nn_mlp_seq.sv
// Time-multiplexed two-layer perceptron: N_IN inputs, N_HID hidden neurons
// and one output neuron evaluated one product per clock on a shared MAC.
module nn_mlp_seq
    import nn_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_HID = 3,
    parameter int DW    = 2,
    parameter int BW    = 4,
    parameter int OW    = 2,
    parameter int ACC_W = 12
) (
    input logic         clk,
    input logic         rst,
    nn_mlp_seq_if.slave bus
);
    localparam int AW     = cfg_aw(N_IN, N_HID);
    localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW     = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int PROD_W = 2 * DW + 1;
    localparam int SUM_W  = (BW > PROD_W) ? BW : PROD_W;
    localparam int TERMS  = ((N_IN > N_HID) ? N_IN : N_HID) + 1;
    localparam int NEED_W = SUM_W + $clog2(TERMS) + 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_HID  = ST_HID;
    localparam logic [1:0] S_OUT  = ST_OUT;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic signed [CLAMP_W-1:0] H_MAX = CLAMP_W'((1 << DW) - 1);
    localparam logic signed [CLAMP_W-1:0] Y_MAX = CLAMP_W'((1 << OW) - 1);

    if (ACC_W < NEED_W || ACC_W > CLAMP_W) begin : g_acc_w_check
        $error("nn_mlp_seq: ACC_W=%0d outside [%0d, %0d]", ACC_W, NEED_W, CLAMP_W);
    end

    logic [1:0]              state;
    logic [IW-1:0]           i_cnt;
    logic [JW-1:0]           j_cnt;
    logic                    last_i;
    logic                    last_j;
    logic                    busy_w;
    logic                    wr_ok;
    logic                    done_r;
    logic [OW-1:0]           y_r;

    logic [DW-1:0]           x_reg [N_IN];
    logic [DW-1:0]           h_reg [N_HID];
    logic signed [DW-1:0]    wh    [N_HID][N_IN];
    logic signed [DW-1:0]    wo    [N_HID];
    logic signed [BW-1:0]    bh    [N_HID];
    logic signed [BW-1:0]    bo;

    logic                    mac_en;
    logic                    mac_preload;
    logic signed [BW-1:0]    mac_bias;
    logic signed [DW-1:0]    mac_coef;
    logic [DW-1:0]           mac_data;
    logic signed [ACC_W-1:0] acc_next;
    logic [DW-1:0]           h_val;
    logic [OW-1:0]           y_val;

    assign last_i = (i_cnt == IW'(N_IN - 1));
    assign last_j = (j_cnt == JW'(N_HID - 1));
    assign busy_w = (state == S_HID) || (state == S_OUT);
    assign wr_ok  = bus.cfg_we && !busy_w;

    assign h_val = DW'(clamp_s(CLAMP_W'(acc_next), '0, H_MAX));
    assign y_val = OW'(clamp_s(CLAMP_W'(acc_next), '0, Y_MAX));

    assign bus.busy = busy_w;
    assign bus.done = done_r;
    assign bus.y    = y_r;

    // Route the current layer's bias, weight and operand into the shared MAC.
    always_comb begin
        mac_en      = 1'b0;
        mac_preload = 1'b0;
        mac_bias    = '0;
        mac_coef    = '0;
        mac_data    = '0;
        case (state)
            S_HID: begin
                mac_en      = 1'b1;
                mac_preload = (i_cnt == '0);
                mac_bias    = bh[j_cnt];
                mac_coef    = wh[j_cnt][i_cnt];
                mac_data    = x_reg[i_cnt];
            end
            S_OUT: begin
                mac_en      = 1'b1;
                mac_preload = (j_cnt == '0);
                mac_bias    = bo;
                mac_coef    = wo[j_cnt];
                mac_data    = h_reg[j_cnt];
            end
            default: ;
        endcase
    end

    nn_mac #(
        .DW    (DW),
        .BW    (BW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (mac_en),
        .preload  (mac_preload),
        .bias     (mac_bias),
        .coef     (mac_coef),
        .data     (mac_data),
        .acc_next (acc_next)
    );

    // Sequencer: walks (j,i) over the hidden layer, then j over the output
    // neuron; y and done are registered together so y is valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            i_cnt  <= '0;
            j_cnt  <= '0;
            done_r <= 1'b0;
            y_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_HID;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                S_HID: begin
                    if (last_i) begin
                        i_cnt <= '0;
                        if (last_j) begin
                            j_cnt <= '0;
                            state <= S_OUT;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (last_j) begin
                        j_cnt  <= '0;
                        state  <= S_DONE;
                        done_r <= 1'b1;
                        y_r    <= y_val;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Input vector is frozen when a start is accepted.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= bus.x_in[i*DW +: DW];
        end
    end

    // Hidden activation is written on the last input term of each neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_HID; j++) h_reg[j] <= '0;
        end else if (state == S_HID && last_i) begin
            h_reg[j_cnt] <= h_val;
        end
    end

    // Configuration bank; writes land only while no evaluation is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_HID; j++) begin
                for (int i = 0; i < N_IN; i++) wh[j][i] <= '0;
                wo[j] <= '0;
                bh[j] <= '0;
            end
            bo <= '0;
        end else if (wr_ok) begin
            for (int j = 0; j < N_HID; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (bus.cfg_addr == AW'(j * N_IN + i))
                        wh[j][i] <= bus.cfg_data[DW-1:0];
                end
                if (bus.cfg_addr == AW'(wo_base(N_IN, N_HID) + j))
                    wo[j] <= bus.cfg_data[DW-1:0];
                if (bus.cfg_addr == AW'(bh_base(N_IN, N_HID) + j))
                    bh[j] <= bus.cfg_data;
            end
            if (bus.cfg_addr == AW'(bo_addr(N_IN, N_HID)))
                bo <= bus.cfg_data;
        end
    end

endmodule

// File: tb/tb_nn_mlp_seq.sv
// Directed bench for nn_mlp_seq in its default configuration.
module tb_nn_mlp_seq;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int          lat;
    int          nbusy;
    int          ndone;
    logic [1:0]  y_done;
    logic [1:0]  y_end;

    nn_mlp_seq_if #(.N_IN(2), .N_HID(3), .DW(2), .BW(4), .OW(2)) bus ();

    nn_mlp_seq #(
        .N_IN(2), .N_HID(3), .DW(2), .BW(4), .OW(2), .ACC_W(12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    // mode 0: plain run; 1: start/cfg/x disturbances while busy; 2: reset at start+4
    task automatic run_eval(input logic [3:0] x, input int mode,
                            output int o_lat, output int o_nbusy, output int o_ndone,
                            output logic [1:0] o_ydone, output logic [1:0] o_yend);
        bus.x_in  = x;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        o_lat   = -1;
        o_nbusy = 0;
        o_ndone = 0;
        o_ydone = 2'bxx;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (bus.busy) o_nbusy++;
            if (bus.done) begin
                o_ndone++;
                if (o_lat < 0) begin
                    o_lat   = cyc;
                    o_ydone = bus.y;
                end
            end
            if (mode == 1 && cyc == 3) begin
                bus.start    = 1'b1;
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 4'd6;
                bus.cfg_data = 4'hE;
                bus.x_in     = 4'hF;
            end
            if (mode == 1 && cyc == 4) begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (mode == 2 && cyc == 4) rst = 1'b1;
            if (mode == 2 && cyc == 5) begin
                rst = 1'b0;
                check("rst_abort_busy", bus.busy, 0);
                check("rst_abort_y", bus.y, 0);
            end
            @(posedge clk); #1;
        end
        o_yend = bus.y;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.start    = 1'b0;
        bus.x_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_y", bus.y, 0);

        // Fresh configuration is all zero: y = clamp(0) = 0.
        run_eval(4'hF, 0, lat, nbusy, ndone, y_done, y_end);
        check("zero_cfg_y", y_done, 0);
        check("zero_cfg_latency", lat, 10);
        check("zero_cfg_ndone", ndone, 1);

        // WH={{1,1},{0,0},{-1,-2}}, WO={1,1,1}, BH={0,1,-1}, BO=0.
        cfg_write(4'd0, 4'h1);
        cfg_write(4'd1, 4'h1);
        cfg_write(4'd2, 4'h0);
        cfg_write(4'd3, 4'h0);
        cfg_write(4'd4, 4'hF);
        cfg_write(4'd5, 4'hE);
        cfg_write(4'd6, 4'h1);
        cfg_write(4'd7, 4'h1);
        cfg_write(4'd8, 4'h1);
        cfg_write(4'd9, 4'h0);
        cfg_write(4'd10, 4'h1);
        cfg_write(4'd11, 4'hF);
        cfg_write(4'd12, 4'h0);

        // x={0,1}: h={1,1,0}, y=2.
        run_eval(4'b0100, 0, lat, nbusy, ndone, y_done, y_end);
        check("basic_y", y_done, 2);
        check("basic_latency", lat, 10);
        check("basic_busy_cycles", nbusy, 9);
        check("basic_ndone", ndone, 1);
        check("basic_y_held", y_end, 2);

        // BO=-8: acc=-6, clamps to 0.
        cfg_write(4'd12, 4'h8);
        run_eval(4'b0100, 0, lat, nbusy, ndone, y_done, y_end);
        check("neg_clamp_y", y_done, 0);
        cfg_write(4'd12, 4'h0);

        // Start, config write and x change while busy are all ignored.
        run_eval(4'b0100, 1, lat, nbusy, ndone, y_done, y_end);
        check("busy_ignore_y", y_done, 2);
        check("busy_ignore_latency", lat, 10);
        check("busy_ignore_ndone", ndone, 1);

        // Address 13 lies past BO and must not alias onto any entry.
        cfg_write(4'd13, 4'h8);
        run_eval(4'b0100, 0, lat, nbusy, ndone, y_done, y_end);
        check("addr13_ignored_y", y_done, 2);

        // Saturation: WH=1, WO=1, BH=7, BO=7, x={3,3} -> h={3,3,3}, acc=16, y=3.
        for (int a = 0; a < 9; a++) cfg_write(4'(a), 4'h1);
        for (int a = 9; a < 13; a++) cfg_write(4'(a), 4'h7);
        run_eval(4'hF, 0, lat, nbusy, ndone, y_done, y_end);
        check("sat_y", y_done, 3);
        check("sat_latency", lat, 10);

        // Reset at start+4 aborts with no done; config comes back zeroed.
        run_eval(4'hF, 2, lat, nbusy, ndone, y_done, y_end);
        check("rst_mid_ndone", ndone, 0);
        check("rst_mid_busy_cycles", nbusy, 4);
        check("rst_mid_y_end", y_end, 0);
        run_eval(4'hF, 0, lat, nbusy, ndone, y_done, y_end);
        check("after_rst_y", y_done, 0);
        check("after_rst_latency", lat, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_mlp_seq.md
Name: nn_mlp_seq

Overview:
- Parametrised, time-multiplexed two-layer perceptron: N_IN inputs, N_HID hidden neurons, one output neuron.
- Weights and biases live in an internal configuration register bank, loaded through a write port.
- A single shared multiply-accumulate unit evaluates one product per clock.
- Replaces purely combinational fixed-size evaluation with a start/busy/done handshake so larger networks fit timing and area.

Parameters:
N_IN, 2, number of network inputs
N_HID, 3, number of hidden neurons
DW, 2, width of inputs (unsigned) and weights (signed two's complement)
BW, 4, width of biases (signed two's complement) and of cfg_data
OW, 2, width of output y (unsigned)
ACC_W, 12, accumulator width (signed); elaboration check ACC_W >= max(BW, 2*DW+1) + clog2(max(N_IN,N_HID)+1) + 1

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
cfg_we  input  1  config write strobe
cfg_addr  input  AW  config address; AW = clog2(N_IN*N_HID + 2*N_HID + 1), derived
cfg_data  input  BW  config data; weight entries use low DW bits, bias entries use all BW bits
start  input  1  request evaluation; sampled only in IDLE
x_in  input  N_IN*DW  input vector; x[i] = x_in[i*DW +: DW]; captured on accepted start
busy  output  1  high while evaluating
done  output  1  one-cycle pulse when y is updated
y  output  OW  network result; held until next done

Behaviour:
- Reset (synchronous, active-high rst): FSM to IDLE; busy=0, done=0, y=0; all config registers, accumulator and hidden-activation registers cleared to 0. Reset asserted mid-evaluation aborts it: no done pulse, y stays 0.
- Address map:
  - WH[j][i] at j*N_IN+i
  - WO[j] at N_IN*N_HID+j
  - BH[j] at N_IN*N_HID+N_HID+j
  - BO at N_IN*N_HID+2*N_HID
  - Writes to addresses beyond BO are ignored.
  - Writes while busy=1 are ignored.
  - Writes in IDLE take effect next cycle.
- FSM states and transitions:
  - IDLE: when start=1, capture x_in and go to HID with j=0, i=0. start while busy is ignored.
  - HID: one cycle per (j,i). In each cycle, acc <= (i==0 ? sxt(BH[j]) : acc) + sxt(WH[j][i]) * zxt(x[i]).
    - After i=N_IN-1: h[j] <= clamp(acc_next, 0, 2^DW-1), then step j.
    - After j=N_HID-1, go to OUT.
  - OUT: one cycle per j. acc <= (j==0 ? sxt(BO) : acc) + sxt(WO[j]) * zxt(h[j]). After j=N_HID-1, go to DONE.
  - DONE: y <= clamp(acc, 0, 2^OW-1), done=1 for this cycle, busy=0, then return to IDLE. start is not accepted in DONE.
- Latency: start sampled at edge T; busy=1 during cycles T+1 .. T+N_HID*N_IN+N_HID; done=1 at cycle T+N_HID*N_IN+N_HID+1 (default configuration: T+10).
- Arithmetic:
  - Products are signed (2*DW+1) bits; the accumulator cannot overflow given the ACC_W check.
  - Activations use ReLU with upper saturation. Negative sums give 0; sums above the range give the maximum value.
- Back-to-back operation: a start held high is accepted in the IDLE cycle following DONE.

Decomposition:
- Shared package nn_pkg holds:
  - FSM state enum (IDLE, HID, OUT, DONE)
  - address-map base constants (WO_BASE, BH_BASE, BO_ADDR) as functions of N_IN/N_HID
  - clog2-derived AW
  - signed clamp function
- One natural sub-module: nn_mac, a signed multiply with bias-preload/accumulate select and a registered accumulator.

Test Plan:
1. Default params. WH={{1,1},{0,0},{-1,-2}}, BH={0,1,-1}, WO={1,1,1}, BO=0, x={0,1}, start -> h={1,1,0}, y=2; done exactly 10 cycles after start accepted; busy high for 9 cycles.
2. Saturation: all WH=1, all WO=1, BH=7, BO=7, x={3,3} -> h={3,3,3}, acc=16, y=3 (clamped).
3. All config zero (fresh after reset), x={3,3}, start -> y=0, done at +10.
4. Negative clamp: as scenario 1 but BO=-8 -> acc=-6, y=0.
5. Protocol: start and cfg_we pulses issued while busy -> ignored; result identical to scenario 1; one done pulse only. Write to address 13 in IDLE -> no register changes.
6. Reset mid-operation: rst for 1 cycle at start+4 -> busy=0 and y=0 next cycle, no done; a following start yields y=0 (config cleared).
